// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/result bundle between the EX stage and the iterative
//               multiply/divide unit (operands, op code, flush, HI/LO, status).
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  // Pipeline side: issues requests and reads HI/LO and status
  modport master (
    output start, md_op, data1, data2, flush,
    input  busy, done, hi, lo
  );

  // Unit side: consumes requests and owns HI/LO
  modport slave (
    input  start, md_op, data1, data2, flush,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32-cycle shift-add multiplier / restoring divider
//               owning the HI/LO registers. Signed operations run on operand
//               magnitudes and get their signs fixed in a final cycle.
//               MTHI/MTLO write in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  wire logic    clk,
  input  wire logic    rst,
  muldiv_unit_if.slave bus
);

  localparam int              CW    = $clog2(XLEN);
  localparam logic [CW-1:0]   C_LAST = CW'(XLEN - 1);

  localparam logic [2:0] C_OP_MTHI = 3'b100;
  localparam logic [2:0] C_OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d;        // multiplicand, or dividend shifting out MSB-first
  logic [XLEN-1:0]     b_q, b_d;        // multiplier shifting out LSB-first, or divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;    // product, or {remainder, quotient}
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;    // operand signs differ (signed ops only)
  logic                rem_neg_q, rem_neg_d;  // dividend was negative (signed ops only)
  logic                div_zero_q, div_zero_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  // Operand magnitudes and sign info for a new request
  logic            w_signed;
  logic            w_sign1;
  logic            w_sign2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;

  assign w_signed = ~bus.md_op[0];
  assign w_sign1  = w_signed & bus.data1[XLEN-1];
  assign w_sign2  = w_signed & bus.data2[XLEN-1];
  assign w_abs1   = w_sign1 ? -bus.data1 : bus.data1;
  assign w_abs2   = w_sign2 ? -bus.data2 : bus.data2;

  // One shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;

  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign w_mul_step = {w_mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step: bring in the next dividend bit, try to subtract
  // the divisor, keep the difference only if it did not go negative.
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_q_bit;
  logic [2*XLEN-1:0] w_div_step;

  assign w_rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, b_q};
  assign w_q_bit    = ~w_diff[XLEN];
  assign w_div_step = {(w_q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       acc_q[XLEN-2:0], w_q_bit};

  // Sign correction applied in FIX. A zero divisor yields an all-ones quotient
  // regardless of sign; the remainder then equals the sampled dividend.
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_prod_fix = neg_q ? -acc_q : acc_q;
  assign w_quot_fix = div_zero_q ? '1 :
                      (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign w_rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.md_op[2] == 1'b0) begin
            a_d        = w_abs1;
            b_d        = w_abs2;
            acc_d      = '0;
            cnt_d      = '0;
            is_div_d   = bus.md_op[1];
            neg_d      = w_sign1 ^ w_sign2;
            rem_neg_d  = w_sign1;
            div_zero_d = bus.md_op[1] & (bus.data2 == '0);
            busy_d     = 1'b1;
            state_d    = S_RUN;
          end else if (bus.md_op == C_OP_MTHI) begin
            hi_d = bus.data1;
          end else if (bus.md_op == C_OP_MTLO) begin
            lo_d = bus.data1;
          end
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = w_div_step;
            a_d   = a_q << 1;
          end else begin
            acc_d = w_mul_step;
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = w_rem_fix;
            lo_d = w_quot_fix;
          end else begin
            hi_d = w_prod_fix[2*XLEN-1:XLEN];
            lo_d = w_prod_fix[XLEN-1:0];
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: vector table of mult/div
//               operations with a HI/LO scoreboard, plus hand-written
//               sequences for MTHI/MTLO, ignored start, flush and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic clk;
  logic rst;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];          // expected {hi, lo} per mult/div
  logic [31:0] cur_hi, cur_lo;   // bench's view of architectural HI/LO

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        b2b;            // next op starts in the done cycle
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("hi_result", {32'd0, bus.hi}, {32'd0, e[63:32]});
        check("lo_result", {32'd0, bus.lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Issue one mult/div at a negedge with the unit idle and follow it to done
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic b2b);
    int cyc;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.data1 = a;
    bus.data2 = b;
    sb_q.push_back({ehi, elo});
    @(negedge clk);
    bus.start = 1'b0;
    bus.data1 = $urandom;
    bus.data2 = $urandom;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(cyc), 64'd33);
    check("done_pulse", {63'd0, bus.done}, 64'd1);
    cur_hi = ehi;
    cur_lo = elo;
    if (!b2b) begin
      @(negedge clk);
      check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
    vecs[2]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[6]  = '{3'b011, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[11] = '{3'b010, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 3'b110;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.flush = 1'b0;
    cur_hi    = '0;
    cur_lo    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

    // MTHI then MTLO on consecutive idle cycles
    bus.start = 1'b1; bus.md_op = 3'b100; bus.data1 = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'h12345678});
    check("mthi_status", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.md_op = 3'b101; bus.data1 = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});
    check("mtlo_status", {62'd0, bus.busy, bus.done}, 64'd0);
    // MTHI blocked by flush; no-op code does nothing
    bus.md_op = 3'b100; bus.data1 = 32'hDEADBEEF; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.md_op = 3'b111;
    @(negedge clk);
    bus.start = 1'b0;
    check("mthi_flushed", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].b2b);
    end

    // Start MULT, try MTLO at cycle 5 (ignored), flush at cycle 10
    bus.start = 1'b1; bus.md_op = 3'b000; bus.data1 = 32'd5; bus.data2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'b101; bus.data1 = 32'h11111111;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_mid_run", {63'd0, bus.busy}, 64'd1);
    check("mtlo_ignored", {32'd0, bus.lo}, {32'd0, cur_lo});
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_done", {63'd0, bus.done}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo", {bus.hi, bus.lo}, {cur_hi, cur_lo});

    // Reset in the middle of RUN
    bus.start = 1'b1; bus.md_op = 3'b011; bus.data1 = 32'd1000; bus.data2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_status", {62'd0, bus.busy, bus.done}, 64'd0);
    check("rst_run_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) @(negedge clk);
    check("rst_run_quiet", {62'd0, bus.busy, bus.done}, 64'd0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
